// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state
// encodings, the instruction memory depth and the word-address shift.
package imem_loader_pkg;

    // Depth of the instruction memory in 32-bit words (64 KiB).
    localparam int IMEM_WORDS = 16384;

    // Byte address = word index << WORD_SHIFT.
    localparam int WORD_SHIFT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake from the host link plus the instruction memory
// write port. The loader uses the slave view; the host/memory side uses master.
interface imem_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Assembles four accepted bytes into a little-endian 32-bit word. The
// complete word is presented combinationally together with the fourth
// byte so the controller can act on the same edge that accepts it.
module imem_loader_byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic        word_complete,
    output logic [31:0] word_out
);

    logic [1:0]  idx;
    logic [31:0] shreg;

    // New bytes enter at the top and shift down, so the first byte ends in [7:0].
    assign word_out      = {byte_in, shreg[31:8]};
    assign word_complete = accept && (idx == 2'd3);

    // Byte index and partial word; both hold their value across rx gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= 2'd0;
            shreg <= 32'd0;
        end else if (clear) begin
            idx   <= 2'd0;
            shreg <= 32'd0;
        end else if (accept) begin
            idx   <= idx + 2'd1;
            shreg <= word_out;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Runtime program loader: receives a little-endian word count followed by
// that many little-endian words, writes them to the instruction memory and
// keeps the CPU in reset until a complete image is in place.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_WORDS = IMEM_WORDS,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    imem_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    localparam logic [31:0] MAX_LEN = MEM_WORDS;

    state_t      state;
    logic [31:0] len;
    logic        accept;
    logic        start_ok;
    logic        word_complete;
    logic [31:0] word;
    logic [31:0] wl_ext;
    logic [31:0] wl_next;

    assign accept   = bus.rx_valid && bus.rx_ready;
    // start is only honoured when no session is running.
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign wl_ext   = 32'(words_loaded);
    assign wl_next  = wl_ext + 32'd1;

    imem_loader_byte_assembler u_asm (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (start_ok),
        .accept        (accept),
        .byte_in       (bus.rx_data),
        .word_complete (word_complete),
        .word_out      (word)
    );

    // Session controller; every output is registered and set on the transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bus.rx_ready <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= BASE_ADDR;
            bus.mem_wdata <= 32'd0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            len          <= 32'd0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state        <= ST_LEN;
                        bus.rx_ready <= 1'b1;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                    end
                end
                ST_LEN: begin
                    if (word_complete) begin
                        len <= word;
                        if (word == 32'd0) begin
                            state        <= ST_DONE;
                            bus.rx_ready <= 1'b0;
                            busy         <= 1'b0;
                            cpu_hold     <= 1'b0;
                            done         <= 1'b1;
                        end else if (word > MAX_LEN) begin
                            // cpu_hold stays high: a truncated image must never run.
                            state        <= ST_ERR;
                            bus.rx_ready <= 1'b0;
                            busy         <= 1'b0;
                            error        <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (word_complete) begin
                        state         <= ST_WRITE;
                        bus.rx_ready  <= 1'b0;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= BASE_ADDR + (wl_ext << WORD_SHIFT);
                        bus.mem_wdata <= word;
                    end
                end
                ST_WRITE: begin
                    words_loaded <= wl_next[CNT_W-1:0];
                    if (wl_next == len) begin
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        state        <= ST_DATA;
                        bus.rx_ready <= 1'b1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    bus.rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the read-only instruction memory.
- Accepts a byte stream from a host link (for example a UART receiver), assembles little-endian 32-bit words, and drives the instruction memory's load/write port.
- Holds the CPU in reset while loading, so the core never fetches a partially written program.
- Replaces the static image file with a runtime-loadable program.

Parameters:
- MEM_WORDS, 16384, depth of the instruction memory in 32-bit words (64 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word aligned.
- CNT_W, 15, width of the word counters; must hold MEM_WORDS.

Ports:
- clk, input, 1, single system clock; rising-edge triggered.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that begins a load session.
- rx_data, input, 8, incoming byte.
- rx_valid, input, 1, rx_data is valid.
- rx_ready, output, 1, loader accepts a byte this cycle.
- mem_we, output, 1, one-cycle write strobe to instruction memory.
- mem_addr, output, 32, byte address, word aligned; memory indexes it with bits [15:2].
- mem_wdata, output, 32, assembled instruction word.
- cpu_hold, output, 1, holds the core in reset; high while busy.
- busy, output, 1, session in progress.
- done, output, 1, load completed successfully; sticky.
- error, output, 1, length exceeds MEM_WORDS; sticky.
- words_loaded, output, CNT_W, words written this session.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE.
  - rx_ready, mem_we, cpu_hold, busy, done, error = 0.
  - mem_addr = BASE_ADDR, mem_wdata = 0, words_loaded = 0.
  - Internal byte counter and length register cleared.
- Byte transfer: a byte is accepted on a rising edge where rx_valid && rx_ready. rx_data is ignored otherwise.
- States:
  - IDLE:
    - rx_ready=0.
    - start=1 → LEN. On the same edge: clear done, error and words_loaded; set busy and cpu_hold.
  - LEN:
    - rx_ready=1.
    - Collect 4 bytes little-endian into the length register N (word count). The first byte is bits [7:0].
    - On the 4th accepted byte, with N taken from the fully assembled value:
      - N==0 → DONE.
      - N>MEM_WORDS → ERR.
      - Otherwise → DATA.
  - DATA:
    - rx_ready=1.
    - Collect 4 bytes little-endian into the word register.
    - On the 4th accepted byte → WRITE.
  - WRITE (exactly 1 cycle):
    - rx_ready=0, mem_we=1.
    - mem_addr = BASE_ADDR + 4*words_loaded.
    - mem_wdata = the assembled word.
    - Next edge: words_loaded increments.
    - If the incremented count == N → DONE; else → DATA.
  - DONE:
    - done=1, busy=0, cpu_hold=0, rx_ready=0.
    - start=1 → LEN (new session).
  - ERR:
    - error=1, busy=0, rx_ready=0.
    - cpu_hold stays 1, so the core never runs a truncated image.
    - start=1 → LEN.
- Timing:
  - mem_we rises on the cycle after the 4th data byte is accepted.
  - rx_ready is low for exactly one cycle per word.
  - Peak rate is 4 bytes per 5 cycles.
- Boundaries and events:
  - start while busy is ignored.
  - Gaps in rx_valid are allowed anywhere in a frame; partial bytes are retained.
  - N==MEM_WORDS is legal; the last write goes to BASE_ADDR + 4*(MEM_WORDS-1).
  - words_loaded never exceeds N. No writes occur outside [BASE_ADDR, BASE_ADDR + 4*N).
  - Reset mid-session aborts immediately:
    - No further mem_we.
    - Already-written words are not rolled back.
    - cpu_hold drops to 0 per the reset value. The system must sequence a fresh load after reset.
- Arithmetic: address computation is unsigned 32-bit and wraps modulo 2^32. The length is compared as an unsigned 32-bit value.

Decomposition:
- Shared include file imem_defs.vh holds:
  - state encodings (IDLE, LEN, DATA, WRITE, DONE, ERR);
  - the IMEM_WORDS constant, shared with the instruction memory;
  - the word-address shift (2).
- One natural sub-module, byte_assembler:
  - 2-bit byte index plus 32-bit little-endian shift/insert register.
  - Inputs: clear and accept.
  - Outputs: word_complete pulse and word value.
  - Reused for both the LEN and DATA phases.

Test Plan:
- Reset: hold rst_n=0 mid-cycle → all outputs at reset values asynchronously, before the next clk edge; mem_we never pulses.
- Two-word load: start, then bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 →
  - mem_we twice: addr 0x0 data 0x00100513, addr 0x4 data 0x00200593.
  - done=1, words_loaded=2, cpu_hold=0.
- Zero length: header 00 00 00 00 → DONE with no mem_we, words_loaded=0.
- Overflow: header 01 40 00 00 (N=16385) → error=1, cpu_hold=1, no mem_we. A later start plus a valid 1-word stream → done=1, error=0.
- Backpressure/gaps: random rx_valid idle cycles inside a 3-word load →
  - identical writes to the gap-free run;
  - rx_ready low exactly one cycle after each 4th data byte;
  - start pulse mid-load ignored.
- Reset mid-load: assert rst_n=0 after 5 of 12 data bytes → immediate IDLE, no further writes. A subsequent full load completes correctly from BASE_ADDR.
